sram_ctrl_async: RTL

//  Synthesizable, parametrised controller that drives an external asynchronous CMOS SRAM
//  (HM-65162 class, CE/OE/WE active-low) from a single clock domain.

---
 rtl/sram_ctrl_async.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/sram_ctrl_async.sv
// sram_ctrl_async
// Single-clock controller for an asynchronous CMOS SRAM (CE/OE/WE active-low).
// The host side uses a req/ack handshake. Every SRAM pin comes straight from a
// flop, and one 8-bit down-counter times each state.
// The optional write-verify readback is enabled by defining SRAM_WR_VERIFY_EN.
module sram_ctrl_async #(
    parameter int          AW     = 11,
    parameter int          DW     = 8,
    parameter logic [7:0]  T_AS   = 8'd1,
    parameter logic [7:0]  T_WP   = 8'd3,
    parameter logic [7:0]  T_WH   = 8'd1,
    parameter logic [7:0]  T_RD   = 8'd5,
    parameter logic [7:0]  T_TURN = 8'd1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          wr_err,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dq_o,
    output logic          sram_dq_oe,
    input  logic [DW-1:0] sram_dq_i,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n
);

`ifdef SRAM_WR_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    // The counter runs from N-1 down to 0, so a state lasts N cycles.
    // A programmed value of 0 is treated as 1.
    localparam logic [7:0] LD_AS   = (T_AS   == 8'd0) ? 8'd0 : T_AS   - 8'd1;
    localparam logic [7:0] LD_WP   = (T_WP   == 8'd0) ? 8'd0 : T_WP   - 8'd1;
    localparam logic [7:0] LD_WH   = (T_WH   == 8'd0) ? 8'd0 : T_WH   - 8'd1;
    localparam logic [7:0] LD_RD   = (T_RD   == 8'd0) ? 8'd0 : T_RD   - 8'd1;
    localparam logic [7:0] LD_TURN = (T_TURN == 8'd0) ? 8'd0 : T_TURN - 8'd1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_SETUP = 3'd1,
        S_WR_PULSE = 3'd2,
        S_WR_HOLD  = 3'd3,
        S_RD_ACC   = 3'd4,
        S_TURN     = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    cnt, cnt_nxt;
    logic          vfy, vfy_nxt;
    logic          ack_nxt;
    logic          busy_nxt;
    logic          wr_err_nxt;
    logic [DW-1:0] rdata_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] dq_nxt;
    logic          ce_n_nxt, oe_n_nxt, we_n_nxt, dq_oe_nxt;
    logic          accept;

    // Next-state, counter, latched request and next pin values
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
        vfy_nxt    = vfy;
        ack_nxt    = 1'b0;
        busy_nxt   = busy;
        wr_err_nxt = wr_err;
        rdata_nxt  = rdata;
        addr_nxt   = sram_addr;
        dq_nxt     = sram_dq_o;
        accept     = 1'b0;

        case (state)
            S_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                end
            end
            S_WR_SETUP: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_WR_PULSE;
                    cnt_nxt   = LD_WP;
                end
            end
            S_WR_PULSE: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_WR_HOLD;
                    cnt_nxt   = LD_WH;
                end
            end
            S_WR_HOLD: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_TURN;
                    cnt_nxt   = LD_TURN;
                    // With readback enabled, the ack is held back until the verify read completes.
                    if (VERIFY_EN) begin
                        vfy_nxt = 1'b1;
                    end else begin
                        ack_nxt = 1'b1;
                    end
                end
            end
            S_RD_ACC: begin
                if (cnt == 8'd0) begin
                    rdata_nxt = sram_dq_i;
                    if (vfy && (sram_dq_i != sram_dq_o)) begin
                        wr_err_nxt = 1'b1;
                    end
                    vfy_nxt   = 1'b0;
                    ack_nxt   = 1'b1;
                    state_nxt = S_TURN;
                    cnt_nxt   = LD_TURN;
                end
            end
            S_TURN: begin
                if (cnt == 8'd0) begin
                    if (vfy) begin
                        state_nxt = S_RD_ACC;
                        cnt_nxt   = LD_RD;
                    end else if (req) begin
                        // The bus is already idle for T_TURN, so a waiting request starts directly.
                        accept = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        if (accept) begin
            addr_nxt  = addr;
            dq_nxt    = wdata;
            busy_nxt  = 1'b1;
            state_nxt = we ? S_WR_SETUP : S_RD_ACC;
            cnt_nxt   = we ? LD_AS : LD_RD;
        end

        // The pins follow the state being entered, so they change on the same edge as the state.
        ce_n_nxt  = !((state_nxt == S_WR_SETUP) || (state_nxt == S_WR_PULSE) ||
                      (state_nxt == S_WR_HOLD)  || (state_nxt == S_RD_ACC));
        oe_n_nxt  = (state_nxt != S_RD_ACC);
        we_n_nxt  = (state_nxt != S_WR_PULSE);
        dq_oe_nxt = (state_nxt == S_WR_SETUP) || (state_nxt == S_WR_PULSE) ||
                    (state_nxt == S_WR_HOLD);
    end

    // State register and registered outputs; reset aborts any access immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            vfy        <= 1'b0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            wr_err     <= 1'b0;
            rdata      <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            vfy        <= vfy_nxt;
            ack        <= ack_nxt;
            busy       <= busy_nxt;
            wr_err     <= wr_err_nxt;
            rdata      <= rdata_nxt;
            sram_addr  <= addr_nxt;
            sram_dq_o  <= dq_nxt;
            sram_dq_oe <= dq_oe_nxt;
            sram_ce_n  <= ce_n_nxt;
            sram_oe_n  <= oe_n_nxt;
            sram_we_n  <= we_n_nxt;
        end
    end

endmodule
